led_seq_ctrl: RTL and testbench

Sequencer and arbiter for the LED driver control ROM. It accepts requests for a normal-mode data frame or a special-mode configuration frame, grants one at a time, and walks the ROM's 6-bit address through the selected 32-step program at a programmable step rate. It reports busy and completion status back to the frame-buffer and configuration logic that sit upstream.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_seq_ctrl_step_prescaler.sv | 35 +++
 rtl/led_seq_ctrl.sv | 119 +++++++++++
 tb/tb_led_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED control-ROM sequencer: program bases,
// last step offset, FSM states and the mode output encoding.
package led_seq_pkg;

  localparam logic [5:0] NORMAL_BASE  = 6'd0;
  localparam logic [5:0] SPECIAL_BASE = 6'd32;
  localparam logic [4:0] PROG_LAST    = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mode output matches addr[5] of the program that is (or was last) running
  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_SPECIAL = 1'b1
  } mode_t;

endpackage

// File: rtl/led_seq_ctrl_step_prescaler.sv
// Step-rate divider: counts 0..DIV-1 and flags the last count of each step.
// tick_next gives the same flag one cycle early so the owner can register
// outputs that must be high exactly in the tick cycle.
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next count: held at zero while cleared, wraps after the last count
  always_comb begin
    count_next = count + CW'(1);
    if (clr || (count == LAST)) count_next = '0;
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

  assign tick      = (count == LAST);
  assign tick_next = (count_next == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// Arbiter and address sequencer for the LED driver control ROM. Grants one
// data or config request at a time and walks the 6-bit ROM address through
// the selected 32-step program, one step every DIV cycles.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_req,
  input  logic       cfg_req,
  output logic       data_ack,
  output logic       cfg_ack,
  output logic [5:0] addr,
  output logic       busy,
  output logic       mode,
  output logic       seq_done
);

  state_t     state;
  state_t     state_next;
  logic       grant_cfg;
  logic       grant_data;
  logic       last_cfg;
  logic       last_cfg_next;
  logic [5:0] base;
  logic [5:0] addr_next;
  logic       mode_next;
  logic       busy_next;
  logic       data_ack_next;
  logic       cfg_ack_next;
  logic       seq_done_next;
  logic       tick;
  logic       tick_next;

  // Prescaler sits at zero in IDLE, so every program starts on a fresh step
  step_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == IDLE),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and arbitration: config wins unless it won last time and
  // data is waiting, so a stream of config frames cannot starve data
  always_comb begin
    state_next = state;
    grant_cfg  = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        grant_cfg  = cfg_req && !(last_cfg && data_req);
        grant_data = data_req && !grant_cfg;
        if (grant_cfg || grant_data) state_next = RUN;
      end
      RUN: begin
        if (tick && (addr[4:0] == PROG_LAST)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; only the 5-bit offset steps so
  // the address never crosses from one program into the other
  always_comb begin
    base          = grant_cfg ? SPECIAL_BASE : NORMAL_BASE;
    addr_next     = addr;
    mode_next     = mode;
    busy_next     = busy;
    last_cfg_next = last_cfg;
    data_ack_next = 1'b0;
    cfg_ack_next  = 1'b0;
    if (grant_cfg || grant_data) begin
      addr_next     = base;
      mode_next     = base[5];
      busy_next     = 1'b1;
      last_cfg_next = grant_cfg;
      data_ack_next = grant_data;
      cfg_ack_next  = grant_cfg;
    end else if ((state == RUN) && tick) begin
      if (addr[4:0] != PROG_LAST) addr_next = {addr[5], addr[4:0] + 5'd1};
      else                        busy_next = 1'b0;
    end
    seq_done_next = (state_next == RUN) && tick_next &&
                    (addr_next[4:0] == PROG_LAST);
  end

  // Output registers; reset parks the ROM on its blanked end-of-special word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= {SPECIAL_BASE[5], PROG_LAST};
      mode     <= MODE_SPECIAL;
      busy     <= 1'b0;
      data_ack <= 1'b0;
      cfg_ack  <= 1'b0;
      seq_done <= 1'b0;
      last_cfg <= 1'b0;
    end else begin
      addr     <= addr_next;
      mode     <= mode_next;
      busy     <= busy_next;
      data_ack <= data_ack_next;
      cfg_ack  <= cfg_ack_next;
      seq_done <= seq_done_next;
      last_cfg <= last_cfg_next;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with three instances at DIV=4, 1 and 2.
module tb_led_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       dr4, cr4, da4, ca4, busy4, mode4, sd4;
  logic [5:0] addr4;
  logic       dr1, cr1, da1, ca1, busy1, mode1, sd1;
  logic [5:0] addr1;
  logic       dr2, cr2, da2, ca2, busy2, mode2, sd2;
  logic [5:0] addr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(.DIV(4)) u4 (
    .clk(clk), .reset(reset), .data_req(dr4), .cfg_req(cr4),
    .data_ack(da4), .cfg_ack(ca4), .addr(addr4), .busy(busy4),
    .mode(mode4), .seq_done(sd4)
  );

  led_seq_ctrl #(.DIV(1)) u1 (
    .clk(clk), .reset(reset), .data_req(dr1), .cfg_req(cr1),
    .data_ack(da1), .cfg_ack(ca1), .addr(addr1), .busy(busy1),
    .mode(mode1), .seq_done(sd1)
  );

  led_seq_ctrl #(.DIV(2)) u2 (
    .clk(clk), .reset(reset), .data_req(dr2), .cfg_req(cr2),
    .data_ack(da2), .cfg_ack(ca2), .addr(addr2), .busy(busy2),
    .mode(mode2), .seq_done(sd2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dr4 = 0; cr4 = 0; dr1 = 0; cr1 = 0; dr2 = 0; cr2 = 0;
    #1 reset = 1'b1;

    // 1: reset holds the parked state
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_addr", addr4, 63);
      chk("rst_mode", mode4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_ack", {da4, ca4, sd4}, 0);
    end
    chk("rst_addr1", addr1, 63);
    chk("rst_addr2", addr2, 63);
    reset = 1'b0;
    step();
    chk("idle_addr", addr4, 63);
    chk("idle_busy", busy4, 0);

    // 2: normal frame at DIV=4
    dr4 = 1;
    step();
    dr4 = 0;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) step();
      chk("n_addr", addr4, i / 4);
      chk("n_busy", busy4, 1);
      chk("n_mode", mode4, 0);
      chk("n_dack", da4, (i == 0));
      chk("n_cack", ca4, 0);
      chk("n_done", sd4, (i == 127));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n_end_busy", busy4, 0);
      chk("n_end_addr", addr4, 31);
      chk("n_end_done", sd4, 0);
    end

    // 5: data request raised during a config frame waits for IDLE
    cr4 = 1;
    step();
    cr4 = 0;
    chk("c_ack", ca4, 1);
    chk("c_addr", addr4, 32);
    chk("c_mode", mode4, 1);
    chk("c_busy", busy4, 1);
    for (int i = 1; i < 128; i++) begin
      step();
      chk("c_addr", addr4, 32 + i / 4);
      chk("c_dack", da4, 0);
      chk("c_cack", ca4, 0);
      chk("c_done", sd4, (i == 127));
      if (i == 10) dr4 = 1;
    end
    step();
    chk("gap_busy", busy4, 0);
    chk("gap_addr", addr4, 63);
    chk("gap_dack", da4, 0);
    step();
    dr4 = 0;
    chk("late_dack", da4, 1);
    chk("late_addr", addr4, 0);
    chk("late_mode", mode4, 0);
    chk("late_busy", busy4, 1);

    // 6: reset in the middle of a normal frame
    repeat (69) step();
    chk("mid_addr", addr4, 17);
    #1 reset = 1'b1;
    #1;
    chk("ar_addr", addr4, 63);
    chk("ar_busy", busy4, 0);
    chk("ar_mode", mode4, 1);
    dr4 = 1;
    step();
    chk("ar_addr2", addr4, 63);
    chk("ar_dack", da4, 0);
    reset = 1'b0;
    step();
    dr4 = 0;
    chk("re_dack", da4, 1);
    chk("re_addr", addr4, 0);
    chk("re_busy", busy4, 1);

    // 3: config frame at DIV=1
    cr1 = 1;
    step();
    cr1 = 0;
    chk("d1_ack", ca1, 1);
    chk("d1_dack", da1, 0);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step();
      chk("d1_addr", addr1, 32 + i);
      chk("d1_mode", mode1, 1);
      chk("d1_busy", busy1, 1);
      chk("d1_done", sd1, (i == 31));
    end
    step();
    chk("d1_end_busy", busy1, 0);
    chk("d1_end_addr", addr1, 63);
    chk("d1_end_done", sd1, 0);

    // 4: both requests held from reset alternate cfg, data, cfg, data
    reset = 1'b1;
    dr2 = 1;
    cr2 = 1;
    step();
    step();
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      step();
      chk("alt_cack", ca2, (f % 2 == 0));
      chk("alt_dack", da2, (f % 2 == 1));
      chk("alt_addr", addr2, (f % 2 == 0) ? 32 : 0);
      chk("alt_mode", mode2, (f % 2 == 0));
      chk("alt_busy", busy2, 1);
      for (int c = 1; c < 64; c++) begin
        step();
        chk("alt_run_busy", busy2, 1);
        chk("alt_run_ack", {da2, ca2}, 0);
        chk("alt_run_done", sd2, (c == 63));
      end
      step();
      chk("alt_idle_busy", busy2, 0);
      chk("alt_idle_addr", addr2, (f % 2 == 0) ? 63 : 31);
      chk("alt_idle_ack", {da2, ca2}, 0);
    end
    dr2 = 0;
    cr2 = 0;
    step();
    chk("alt_stop_busy", busy2, 0);
    chk("alt_stop_ack", {da2, ca2}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
